// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int          FCNT_W  = 16;
  localparam int          HOLD_W  = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// Next-PC selection: jump > taken branch > sequential, with alignment and limit wrap.
module pc_next_mux
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT   = 32'd36
) (
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        accept,
  output logic [31:0] next_pc,
  output logic        wrap
);

  logic [31:0] candidate;
  logic        advance;

  always_comb begin
    candidate = pc;
    advance   = 1'b1;
    if (jump) begin
      candidate = word_align(jump_target);
    end else if (branch_taken) begin
      candidate = word_align(branch_target);
    end else if (accept) begin
      candidate = pc + PC_STEP;
    end else begin
      advance = 1'b0;
    end
  end

  // A held PC never wraps; only a real move past the limit does.
  always_comb begin
    wrap    = advance && (candidate > PC_LIMIT);
    next_pc = wrap ? RESET_ADDR : candidate;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, post-reset hold, redirects, halt and wrap.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT    = 32'd36,
  parameter int          HOLD_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  input  logic        ImemAck,
  output logic [31:0] PC,
  output logic        ImemReq,
  output logic        InstrValid,
  output logic [31:0] InstrPC,
  output logic        Flush,
  output logic        Wrapped,
  output logic        Halted,
  output logic [15:0] FetchCount
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

  fetch_state_e      state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       pc_p0;
  logic              instr_valid_p1;
  logic [31:0]       instr_pc_p1;
  logic              flush_p1;
  logic              wrapped_p1;
  logic [FCNT_W-1:0] fetch_count;

  logic              req;
  logic              accept;
  logic [31:0]       next_pc;
  logic              wrap;

  // Any redirect or halt masks the request so it can never coincide with an accept.
  assign req    = (state == ST_FETCH) & ~Stall & ~Halt & ~Jump & ~BranchTaken;
  assign accept = req & ImemAck;

  pc_next_mux #(
    .RESET_ADDR (RESET_ADDR),
    .PC_LIMIT   (PC_LIMIT)
  ) u_pc_next_mux (
    .pc            (pc_p0),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .branch_taken  (BranchTaken),
    .branch_target (BranchTarget),
    .accept        (accept),
    .next_pc       (next_pc),
    .wrap          (wrap)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= ST_HOLD;
      hold_cnt       <= HOLD_INIT;
      pc_p0          <= RESET_ADDR;
      instr_valid_p1 <= 1'b0;
      instr_pc_p1    <= 32'h0;
      flush_p1       <= 1'b0;
      wrapped_p1     <= 1'b0;
      fetch_count    <= '0;
    end else begin
      instr_valid_p1 <= 1'b0;
      flush_p1       <= 1'b0;
      wrapped_p1     <= 1'b0;
      case (state)
        ST_HOLD: begin
          pc_p0    <= RESET_ADDR;
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt <= HOLD_W'(1)) begin
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (Halt) begin
            state <= ST_HALT;
          end else begin
            // Fetch / redirect -> completion stage
            pc_p0      <= next_pc;
            flush_p1   <= Jump | BranchTaken;
            wrapped_p1 <= wrap;
            if (accept) begin
              instr_valid_p1 <= 1'b1;
              instr_pc_p1    <= pc_p0;
              if (fetch_count != '1) begin
                fetch_count <= fetch_count + 1'b1;
              end
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

  assign PC         = pc_p0;
  assign ImemReq    = req;
  assign InstrValid = instr_valid_p1;
  assign InstrPC    = instr_pc_p1;
  assign Flush      = flush_p1;
  assign Wrapped    = wrapped_p1;
  assign Halted     = (state == ST_HALT);
  assign FetchCount = fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (default parameters).
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] JumpTarget = 32'h0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Halt = 1'b0;
  logic        ImemAck = 1'b0;
  logic [31:0] PC;
  logic        ImemReq;
  logic        InstrValid;
  logic [31:0] InstrPC;
  logic        Flush;
  logic        Wrapped;
  logic        Halted;
  logic [15:0] FetchCount;

  int total = 0;
  int bad = 0;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump), .JumpTarget(JumpTarget),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Halt(Halt), .ImemAck(ImemAck),
    .PC(PC), .ImemReq(ImemReq), .InstrValid(InstrValid), .InstrPC(InstrPC), .Flush(Flush),
    .Wrapped(Wrapped), .Halted(Halted), .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; ImemAck = 1'b1;
    #1;
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", PC, 32'h0); end
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", ImemReq); end
    total++; if (InstrValid !== 1'b0 || InstrPC !== 32'h0) begin bad++; $display("FAIL reset_instr got=%b/%h want=0/0", InstrValid, InstrPC); end
    total++; if ({Flush, Wrapped, Halted} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {Flush, Wrapped, Halted}); end
    total++; if (FetchCount !== 16'h0) begin bad++; $display("FAIL reset_count got=%0d want=0", FetchCount); end
    step();
    Reset = 1'b0;
    #1;
    total++; if (ImemReq !== 1'b0 || PC !== 32'h0) begin bad++; $display("FAIL hold_cycle got req=%b pc=%h want req=0 pc=0", ImemReq, PC); end
  endtask

  task automatic test_sequential();
    step();
    total++; if (ImemReq !== 1'b1 || PC !== 32'h0 || InstrValid !== 1'b0) begin bad++; $display("FAIL first_fetch got req=%b pc=%h vld=%b want 1/0/0", ImemReq, PC, InstrValid); end
    for (int i = 1; i <= 2; i++) begin
      step();
      total++; if (PC !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc got=%h want=%h", PC, 32'(4 * i)); end
      total++; if (InstrValid !== 1'b1 || InstrPC !== 32'(4 * (i - 1))) begin bad++; $display("FAIL seq_instr got=%b/%h want=1/%h", InstrValid, InstrPC, 32'(4 * (i - 1))); end
      total++; if (FetchCount !== 16'(i)) begin bad++; $display("FAIL seq_count got=%0d want=%0d", FetchCount, i); end
    end
  endtask

  task automatic test_wait_state();
    ImemAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (PC !== 32'h8 || ImemReq !== 1'b1) begin bad++; $display("FAIL wait_hold got pc=%h req=%b want 8/1", PC, ImemReq); end
      step();
      total++; if (InstrValid !== 1'b0) begin bad++; $display("FAIL wait_novalid got=%b want=0", InstrValid); end
    end
    ImemAck = 1'b1;
    step();
    total++; if (PC !== 32'hC || InstrValid !== 1'b1 || InstrPC !== 32'h8) begin bad++; $display("FAIL wait_ack got pc=%h vld=%b ipc=%h want c/1/8", PC, InstrValid, InstrPC); end
    total++; if (FetchCount !== 16'd3) begin bad++; $display("FAIL wait_count got=%0d want=3", FetchCount); end
    ImemAck = 1'b0;
    step();
    total++; if (InstrValid !== 1'b0 || PC !== 32'hC) begin bad++; $display("FAIL wait_single got vld=%b pc=%h want 0/c", InstrValid, PC); end
  endtask

  task automatic test_redirect();
    Stall = 1'b1; ImemAck = 1'b1;
    Jump = 1'b1; JumpTarget = 32'h14;
    BranchTaken = 1'b1; BranchTarget = 32'h20;
    #1;
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL redir_req got=%b want=0", ImemReq); end
    step();
    Jump = 1'b0; BranchTaken = 1'b0;
    total++; if (PC !== 32'h14 || Flush !== 1'b1) begin bad++; $display("FAIL redir_jump got pc=%h flush=%b want 14/1", PC, Flush); end
    total++; if (FetchCount !== 16'd3 || InstrValid !== 1'b0) begin bad++; $display("FAIL redir_count got=%0d vld=%b want 3/0", FetchCount, InstrValid); end
    #1;
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL stall_req got=%b want=0", ImemReq); end
    step();
    total++; if (PC !== 32'h14 || Flush !== 1'b0 || FetchCount !== 16'd3) begin bad++; $display("FAIL stall_hold got pc=%h flush=%b cnt=%0d want 14/0/3", PC, Flush, FetchCount); end
    Stall = 1'b0;
    BranchTaken = 1'b1; BranchTarget = 32'h1B;
    step();
    BranchTaken = 1'b0;
    total++; if (PC !== 32'h18 || Flush !== 1'b1 || InstrValid !== 1'b0) begin bad++; $display("FAIL branch_align got pc=%h flush=%b vld=%b want 18/1/0", PC, Flush, InstrValid); end
  endtask

  task automatic test_wrap();
    ImemAck = 1'b0;
    Jump = 1'b1; JumpTarget = 32'h27;
    step();
    Jump = 1'b0;
    total++; if (PC !== 32'h24 || Wrapped !== 1'b0) begin bad++; $display("FAIL limit_edge got pc=%h wrap=%b want 24/0", PC, Wrapped); end
    ImemAck = 1'b1;
    step();
    ImemAck = 1'b0;
    total++; if (PC !== 32'h0 || Wrapped !== 1'b1) begin bad++; $display("FAIL wrap_seq got pc=%h wrap=%b want 0/1", PC, Wrapped); end
    total++; if (InstrValid !== 1'b1 || InstrPC !== 32'h24 || FetchCount !== 16'd4) begin bad++; $display("FAIL wrap_instr got vld=%b ipc=%h cnt=%0d want 1/24/4", InstrValid, InstrPC, FetchCount); end
    step();
    total++; if (Wrapped !== 1'b0) begin bad++; $display("FAIL wrap_pulse got=%b want=0", Wrapped); end
    Jump = 1'b1; JumpTarget = 32'h2B;
    step();
    Jump = 1'b0;
    total++; if (PC !== 32'h0 || Wrapped !== 1'b1 || Flush !== 1'b1) begin bad++; $display("FAIL wrap_jump got pc=%h wrap=%b flush=%b want 0/1/1", PC, Wrapped, Flush); end
  endtask

  task automatic test_halt();
    Jump = 1'b1; JumpTarget = 32'hC;
    step();
    Jump = 1'b0;
    Halt = 1'b1; ImemAck = 1'b1;
    #1;
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL halt_req got=%b want=0", ImemReq); end
    step();
    Halt = 1'b0;
    Jump = 1'b1; JumpTarget = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (Halted !== 1'b1 || ImemReq !== 1'b0 || PC !== 32'hC) begin bad++; $display("FAIL halt_frozen got halted=%b req=%b pc=%h want 1/0/c", Halted, ImemReq, PC); end
      step();
    end
    total++; if (InstrValid !== 1'b0 || FetchCount !== 16'd4 || Flush !== 1'b0) begin bad++; $display("FAIL halt_regs got vld=%b cnt=%0d flush=%b want 0/4/0", InstrValid, FetchCount, Flush); end
    Jump = 1'b0;
    Reset = 1'b1;
    #1;
    total++; if (Halted !== 1'b0 || PC !== 32'h0) begin bad++; $display("FAIL halt_reset got halted=%b pc=%h want 0/0", Halted, PC); end
    step();
    Reset = 1'b0;
    #1;
    total++; if (ImemReq !== 1'b0) begin bad++; $display("FAIL halt_rehold got req=%b want=0", ImemReq); end
  endtask

  task automatic test_async_reset();
    ImemAck = 1'b0;
    step();
    Jump = 1'b1; JumpTarget = 32'h14;
    step();
    Jump = 1'b0;
    step();
    total++; if (PC !== 32'h14 || ImemReq !== 1'b1) begin bad++; $display("FAIL areset_setup got pc=%h req=%b want 14/1", PC, ImemReq); end
    #2;
    Reset = 1'b1;
    #1;
    total++; if (PC !== 32'h0 || ImemReq !== 1'b0 || FetchCount !== 16'h0) begin bad++; $display("FAIL areset_now got pc=%h req=%b cnt=%0d want 0/0/0", PC, ImemReq, FetchCount); end
    total++; if (InstrValid !== 1'b0 || InstrPC !== 32'h0 || Flush !== 1'b0 || Wrapped !== 1'b0) begin bad++; $display("FAIL areset_outs got vld=%b ipc=%h flush=%b wrap=%b want 0/0/0/0", InstrValid, InstrPC, Flush, Wrapped); end
    ImemAck = 1'b1;
    step();
    Reset = 1'b0;
    step();
    total++; if (InstrValid !== 1'b0) begin bad++; $display("FAIL areset_drop got vld=%b want=0", InstrValid); end
    step();
    total++; if (InstrValid !== 1'b1 || InstrPC !== 32'h0 || PC !== 32'h4) begin bad++; $display("FAIL areset_restart got vld=%b ipc=%h pc=%h want 1/0/4", InstrValid, InstrPC, PC); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_state();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
